control_fsm: RTL and testbench

//  Multicycle main control unit: the FSM that produces aluOp for aluDeco and every datapath enable.

---
 rtl/control_fsm_pkg.sv | 103 ++++++++++
 rtl/control_fsm_imm_deco.sv | 19 +
 rtl/control_fsm.sv | 83 ++++++++
 tb/tb_control_fsm.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/control_fsm_pkg.sv
// Shared definitions for the multicycle main control unit: opcodes, state codes,
// aluOp codes shared with aluDeco, and the Moore output decode of each state.
package control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam state_t RESET_STATE = S_FETCH;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef struct packed {
    logic [1:0] aluOp;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] resultSrc;
    logic       adrSrc;
    logic       irWrite;
    logic       pcUpdate;
    logic       branch;
    logic       regWrite;
    logic       memWrite;
  } ctrl_t;

  // Unlisted codes (including 11..15) decode to all-zero controls.
  function automatic ctrl_t state_decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.irWrite   = 1'b1;
        c.aluSrcB   = 2'b10;
        c.resultSrc = 2'b10;
        c.pcUpdate  = 1'b1;
      end
      S_DECODE: begin
        c.aluSrcA = 2'b01;
        c.aluSrcB = 2'b01;
      end
      S_MEMADR: begin
        c.aluSrcA = 2'b10;
        c.aluSrcB = 2'b01;
      end
      S_MEMREAD: c.adrSrc = 1'b1;
      S_MEMWB: begin
        c.resultSrc = 2'b01;
        c.regWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adrSrc   = 1'b1;
        c.memWrite = 1'b1;
      end
      S_EXECR: begin
        c.aluSrcA = 2'b10;
        c.aluOp   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        c.aluSrcA = 2'b10;
        c.aluSrcB = 2'b01;
        c.aluOp   = ALUOP_FUNCT;
      end
      S_ALUWB: c.regWrite = 1'b1;
      S_BEQ: begin
        c.aluSrcA = 2'b10;
        c.aluOp   = ALUOP_SUB;
        c.branch  = 1'b1;
      end
      S_JAL: begin
        c.aluSrcA  = 2'b01;
        c.aluSrcB  = 2'b10;
        c.pcUpdate = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/control_fsm_imm_deco.sv
// Immediate-format select from the opcode; purely combinational, independent of state.
module imm_deco
  import control_fsm_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] immSrc
);

  always_comb begin
    immSrc = IMM_I;
    case (op)
      OP_SW:   immSrc = IMM_S;
      OP_BEQ:  immSrc = IMM_B;
      OP_JAL:  immSrc = IMM_J;
      default: immSrc = IMM_I;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multicycle main control FSM: sequences lw/sw/R/I/beq/jal one state per clock
// and drives every datapath enable and select.
module control_fsm
  import control_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  output logic [1:0] aluOp,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] resultSrc,
  output logic       adrSrc,
  output logic       irWrite,
  output logic       pcWrite,
  output logic       regWrite,
  output logic       memWrite,
  output logic [1:0] immSrc,
  output logic       illegalOp
);

  state_t r_state;
  state_t w_next;
  ctrl_t  r_ctrl;
  logic   w_op_known;

  assign w_op_known = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                      (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL:       w_next = S_JAL;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR:  w_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: w_next = S_MEMWB;
      S_EXECR:   w_next = S_ALUWB;
      S_EXECI:   w_next = S_ALUWB;
      S_JAL:     w_next = S_ALUWB;
      default:   w_next = S_FETCH;
    endcase
  end

  // Controls are registered from the next state, so they always equal the
  // Moore decode of r_state, and reset forces the FETCH pattern at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RESET_STATE;
      r_ctrl  <= state_decode(RESET_STATE);
    end else begin
      r_state <= w_next;
      r_ctrl  <= state_decode(w_next);
    end
  end

  assign aluOp     = r_ctrl.aluOp;
  assign aluSrcA   = r_ctrl.aluSrcA;
  assign aluSrcB   = r_ctrl.aluSrcB;
  assign resultSrc = r_ctrl.resultSrc;
  assign adrSrc    = r_ctrl.adrSrc;
  assign irWrite   = r_ctrl.irWrite;
  assign regWrite  = r_ctrl.regWrite;
  assign memWrite  = r_ctrl.memWrite;
  assign pcWrite   = r_ctrl.pcUpdate | (r_ctrl.branch & zero);
  // op is only meaningful once the IR has loaded, hence DECODE-qualified.
  assign illegalOp = (r_state == S_DECODE) && !w_op_known;

  imm_deco u_imm_deco (
    .op     (op),
    .immSrc (immSrc)
  );

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: walks each instruction class through its states
// and checks the packed control vector, state code and immSrc at every step.
module tb_control_fsm;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic       zero;
  logic [1:0] aluOp, aluSrcA, aluSrcB, resultSrc, immSrc;
  logic       adrSrc, irWrite, pcWrite, regWrite, memWrite, illegalOp;

  int checks = 0;
  int errors = 0;

  control_fsm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .zero      (zero),
    .aluOp     (aluOp),
    .aluSrcA   (aluSrcA),
    .aluSrcB   (aluSrcB),
    .resultSrc (resultSrc),
    .adrSrc    (adrSrc),
    .irWrite   (irWrite),
    .pcWrite   (pcWrite),
    .regWrite  (regWrite),
    .memWrite  (memWrite),
    .immSrc    (immSrc),
    .illegalOp (illegalOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed order: aluOp, aluSrcA, aluSrcB, resultSrc, adrSrc, irWrite, pcWrite, regWrite, memWrite, illegalOp
  function automatic logic [13:0] pack(input logic [1:0] ao, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [1:0] rs,
                                       input logic ad, input logic ir, input logic pw,
                                       input logic rw, input logic mw, input logic il);
    return {ao, sa, sb, rs, ad, ir, pw, rw, mw, il};
  endfunction

  function automatic logic [13:0] observed();
    return {aluOp, aluSrcA, aluSrcB, resultSrc, adrSrc, irWrite, pcWrite, regWrite, memWrite, illegalOp};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_step(input string tag, input logic [3:0] exp_state, input logic [13:0] exp_ctrl);
    check({tag, ".state"}, {12'd0, 4'(dut.r_state)}, {12'd0, exp_state});
    check({tag, ".ctrl"}, {2'b00, observed()}, {2'b00, exp_ctrl});
    $display("step %-10s state=%0d ctrl=%b immSrc=%b", tag, 4'(dut.r_state), observed(), immSrc);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  localparam logic [13:0] C_FETCH = 14'b00_00_10_10_0_1_1_0_0_0;

  initial begin
    rst_n = 1'b0;
    op    = 7'b0000011;
    zero  = 1'b0;
    @(negedge clk);
    check_step("reset", 4'd0, C_FETCH);
    rst_n = 1'b1;

    // lw: 0,1,2,3,4,0
    check("lw.imm", {14'd0, immSrc}, 16'd0);
    step(); check_step("lw.decode", 4'd1, pack(2'b00, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
    step(); check_step("lw.memadr", 4'd2, pack(2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
    step(); check_step("lw.memread", 4'd3, pack(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0));
    step(); check_step("lw.memwb", 4'd4, pack(2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0, 1, 0, 0));
    step(); check_step("lw.fetch", 4'd0, C_FETCH);

    // sw: 0,1,2,5 then reset during MEMWRITE
    op = 7'b0100011;
    #1 check("sw.imm", {14'd0, immSrc}, 16'd1);
    step(); check_step("sw.decode", 4'd1, pack(2'b00, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
    step(); check_step("sw.memadr", 4'd2, pack(2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
    step(); check_step("sw.memwrite", 4'd5, pack(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 1, 0));
    #2 rst_n = 1'b0;
    #1 check_step("rst.midwrite", 4'd0, C_FETCH);
    @(negedge clk);
    rst_n = 1'b1;
    check_step("rst.held", 4'd0, C_FETCH);
    step(); check_step("sw2.decode", 4'd1, pack(2'b00, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
    step(); check_step("sw2.memadr", 4'd2, pack(2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
    step(); check_step("sw2.memwrite", 4'd5, pack(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 1, 0));
    step(); check_step("sw2.fetch", 4'd0, C_FETCH);

    // R-type
    op = 7'b0110011;
    step(); check_step("r.decode", 4'd1, pack(2'b00, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
    step(); check_step("r.execr", 4'd6, pack(2'b10, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
    step(); check_step("r.aluwb", 4'd8, pack(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0));
    step(); check_step("r.fetch", 4'd0, C_FETCH);

    // I-type
    op = 7'b0010011;
    #1 check("i.imm", {14'd0, immSrc}, 16'd0);
    step(); check_step("i.decode", 4'd1, pack(2'b00, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
    step(); check_step("i.execi", 4'd7, pack(2'b10, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
    step(); check_step("i.aluwb", 4'd8, pack(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0));
    step(); check_step("i.fetch", 4'd0, C_FETCH);

    // beq: pcWrite follows zero within the BEQ cycle
    op = 7'b1100011;
    zero = 1'b1;
    #1 check("beq.imm", {14'd0, immSrc}, 16'd2);
    step(); check_step("beq.decode", 4'd1, pack(2'b00, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
    step(); check_step("beq.z1", 4'd9, pack(2'b01, 2'b10, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0));
    zero = 1'b0;
    #1 check_step("beq.z0", 4'd9, pack(2'b01, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
    step(); check_step("beq.fetch", 4'd0, C_FETCH);

    // jal
    op = 7'b1101111;
    #1 check("jal.imm", {14'd0, immSrc}, 16'd3);
    step(); check_step("jal.decode", 4'd1, pack(2'b00, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
    step(); check_step("jal.jal", 4'd10, pack(2'b00, 2'b01, 2'b10, 2'b00, 0, 0, 1, 0, 0, 0));
    step(); check_step("jal.aluwb", 4'd8, pack(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0));
    step(); check_step("jal.fetch", 4'd0, C_FETCH);

    // illegal opcode: one-cycle pulse in DECODE, then FETCH
    op = 7'b1111111;
    #1 check("ill.imm", {14'd0, immSrc}, 16'd0);
    step(); check_step("ill.decode", 4'd1, pack(2'b00, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 1));
    step(); check_step("ill.fetch", 4'd0, C_FETCH);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
